// File: rtl/tdm_demux_pkg.sv
// ============================================================================
// Module   : tdm_demux_pkg
// Brief    : Shared types and constants for the 4-channel TDM demultiplexer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tdm_demux_pkg;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int NUM_SLOTS = 4;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_A = 2'b00;
    localparam slot_t SLOT_B = 2'b01;
    localparam slot_t SLOT_C = 2'b10;
    localparam slot_t SLOT_D = 2'b11;

    localparam int FRAME_CNT_W = 16;
    localparam int ERR_CNT_W   = 8;

endpackage

`default_nettype wire

// File: rtl/tdm_demux_4ch_if.sv
// ============================================================================
// Module   : tdm_demux_4ch_if
// Brief    : Stream-in / channels-out bundle of the TDM demux. Optional
//            counters exist when TDM_DEMUX_FRAME_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tdm_demux_4ch_if
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             s1;
    logic             s0;
    logic             locked;
    logic             sync_err;
`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic [ERR_CNT_W-1:0]   err_cnt;

    modport master (
        output din, din_valid, frame_sync,
        input  a, b, c, d, out_valid, s1, s0, locked, sync_err, frame_cnt, err_cnt
    );
    modport slave (
        input  din, din_valid, frame_sync,
        output a, b, c, d, out_valid, s1, s0, locked, sync_err, frame_cnt, err_cnt
    );
`else
    modport master (
        output din, din_valid, frame_sync,
        input  a, b, c, d, out_valid, s1, s0, locked, sync_err
    );
    modport slave (
        input  din, din_valid, frame_sync,
        output a, b, c, d, out_valid, s1, s0, locked, sync_err
    );
`endif

endinterface

`default_nettype wire

// File: rtl/tdm_slot_ctr.sv
// ============================================================================
// Module   : tdm_slot_ctr
// Brief    : 2-bit wrapping slot counter with resync load-to-01 and advance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_slot_ctr
    import tdm_demux_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_load,
    input  wire logic i_adv,
    output logic      o_s1,
    output logic      o_s0
);

    slot_t r_slot;

    // A resync beat is itself slot 0, so the next expected slot is 01.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot <= SLOT_A;
        end else if (i_load) begin
            r_slot <= SLOT_B;
        end else if (i_adv) begin
            r_slot <= r_slot + 2'd1;
        end
    end

    assign o_s1 = r_slot[1];
    assign o_s0 = r_slot[0];

endmodule

`default_nettype wire

// File: rtl/tdm_demux_4ch.sv
// ============================================================================
// Module   : tdm_demux_4ch
// Brief    : 4-channel TDM demultiplexer with slot-0 marker alignment.
//            Optional frame/error counters: TDM_DEMUX_FRAME_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux_4ch
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 1
)(
    input  wire logic       clk,
    input  wire logic       rst_n,
    tdm_demux_4ch_if.slave  bus
);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_stage_a, r_stage_b, r_stage_c;
    logic [WIDTH-1:0] w_stage_a_nxt, w_stage_b_nxt, w_stage_c_nxt;
    logic [WIDTH-1:0] r_a, r_b, r_c, r_d;
    logic             r_out_valid, r_sync_err;
    logic             w_load, w_adv, w_err, w_done;
    slot_t            w_slot;

    tdm_slot_ctr u_slot_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_adv  (w_adv),
        .o_s1   (bus.s1),
        .o_s0   (bus.s0)
    );

    assign w_slot = {bus.s1, bus.s0};

    always_comb begin
        w_state_nxt   = r_state;
        w_stage_a_nxt = r_stage_a;
        w_stage_b_nxt = r_stage_b;
        w_stage_c_nxt = r_stage_c;
        w_load        = 1'b0;
        w_adv         = 1'b0;
        w_err         = 1'b0;
        w_done        = 1'b0;
        if (bus.din_valid) begin
            case (r_state)
                HUNT: begin
                    if (bus.frame_sync) begin
                        w_stage_a_nxt = bus.din;
                        w_load        = 1'b1;
                        w_state_nxt   = LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_slot == SLOT_A) begin
                        if (bus.frame_sync) begin
                            w_stage_a_nxt = bus.din;
                            w_adv         = 1'b1;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = HUNT;
                        end
                    end else if (bus.frame_sync) begin
                        // Early marker: restart the frame on this beat.
                        w_err         = 1'b1;
                        w_stage_a_nxt = bus.din;
                        w_load        = 1'b1;
                    end else begin
                        w_adv = 1'b1;
                        case (w_slot)
                            SLOT_B:  w_stage_b_nxt = bus.din;
                            SLOT_C:  w_stage_c_nxt = bus.din;
                            SLOT_D:  w_done        = 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= HUNT;
            r_stage_a   <= '0;
            r_stage_b   <= '0;
            r_stage_c   <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stage_a   <= w_stage_a_nxt;
            r_stage_b   <= w_stage_b_nxt;
            r_stage_c   <= w_stage_c_nxt;
            r_out_valid <= w_done;
            r_sync_err  <= w_err;
            if (w_done) begin
                r_a <= r_stage_a;
                r_b <= r_stage_b;
                r_c <= r_stage_c;
                r_d <= bus.din;
            end
        end
    end

    assign bus.a         = r_a;
    assign bus.b         = r_b;
    assign bus.c         = r_c;
    assign bus.d         = r_d;
    assign bus.out_valid = r_out_valid;
    assign bus.sync_err  = r_sync_err;
    assign bus.locked    = (r_state == LOCKED);

`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_done) begin
                r_frame_cnt <= r_frame_cnt + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.frame_cnt = r_frame_cnt;
    assign bus.err_cnt   = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux_4ch.sv
// ============================================================================
// Module   : tb_tdm_demux_4ch
// Brief    : Directed and randomized checks of tdm_demux_4ch against a
//            frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux_4ch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    tdm_demux_4ch_if #(.WIDTH(8)) bus ();

    tdm_demux_4ch #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: position within the frame and the beats collected so far.
    bit         m_locked;
    int         m_pos;
    logic [7:0] m_frame[$];
    logic [7:0] m_out[4];
    bit         m_ov, m_err;
    int         m_fcnt, m_ecnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_pos    = 0;
        m_frame.delete();
        for (int i = 0; i < 4; i++) m_out[i] = '0;
        m_ov   = 0;
        m_err  = 0;
        m_fcnt = 0;
        m_ecnt = 0;
    endtask

    task automatic model_beat(input logic [7:0] v_din, input bit v_fs);
        m_ov  = 0;
        m_err = 0;
        if (!m_locked) begin
            if (v_fs) begin
                m_frame  = '{v_din};
                m_pos    = 1;
                m_locked = 1;
            end
        end else if (m_pos == 0) begin
            if (v_fs) begin
                m_frame = '{v_din};
                m_pos   = 1;
            end else begin
                m_err    = 1;
                m_locked = 0;
            end
        end else if (v_fs) begin
            m_err   = 1;
            m_frame = '{v_din};
            m_pos   = 1;
        end else begin
            m_frame.push_back(v_din);
            m_pos++;
            if (m_pos == 4) begin
                for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
                m_ov   = 1;
                m_pos  = 0;
                m_fcnt = (m_fcnt + 1) % 65536;
            end
        end
        if (m_err && m_ecnt < 255) m_ecnt++;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".abcd"}, {32'd0, bus.a, bus.b, bus.c, bus.d},
              {32'd0, m_out[0], m_out[1], m_out[2], m_out[3]});
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_ov));
        check({tag, ".sync_err"},  64'(bus.sync_err),  64'(m_err));
        check({tag, ".locked"},    64'(bus.locked),    64'(m_locked));
        check({tag, ".slot"},      64'({bus.s1, bus.s0}), 64'(m_locked ? m_pos : 0));
`ifdef TDM_DEMUX_FRAME_CNT_EN
        check({tag, ".frame_cnt"}, 64'(bus.frame_cnt), 64'(m_fcnt));
        check({tag, ".err_cnt"},   64'(bus.err_cnt),   64'(m_ecnt));
`endif
    endtask

    task automatic step(input string tag, input bit v, input logic [7:0] v_din, input bit v_fs);
        @(negedge clk);
        bus.din_valid  = v;
        bus.din        = v_din;
        bus.frame_sync = v_fs;
        @(posedge clk);
        if (v) model_beat(v_din, v_fs);
        else begin
            m_ov  = 0;
            m_err = 0;
        end
        #1;
        check_all(tag);
    endtask

    // Reset is applied together with a live sync beat to show it takes priority.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n          = 1'b0;
        bus.din_valid  = 1'b1;
        bus.frame_sync = 1'b1;
        bus.din        = 8'($urandom);
        @(posedge clk);
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.din_valid = 1'b0;
    endtask

    task automatic send_frame(input string tag, input logic [7:0] w0, w1, w2, w3);
        step(tag, 1, w0, 1);
        step(tag, 1, w1, 0);
        step(tag, 1, w2, 0);
        step(tag, 1, w3, 0);
    endtask

    initial begin
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        model_reset();

        do_reset("reset");

        send_frame("frame1", 8'd1, 8'd2, 8'd3, 8'd4);
        step("idle", 0, 8'hAA, 1);

        send_frame("b2b_a", 8'd10, 8'd11, 8'd12, 8'd13);
        send_frame("b2b_b", 8'd20, 8'd21, 8'd22, 8'd23);
        check("b2b_final", {32'd0, bus.a, bus.b, bus.c, bus.d}, 64'h14151617);

        do_reset("reset2");
        step("hunt_drop", 1, 8'd5, 0);
        step("hunt_drop", 1, 8'd6, 0);
        send_frame("hunt_lock", 8'd7, 8'd8, 8'd9, 8'd10);

        step("resync", 1, 8'($urandom), 1);
        step("resync", 1, 8'($urandom), 0);
        send_frame("resync_new", 8'd40, 8'd41, 8'd42, 8'd43);
        check("resync_final", {32'd0, bus.a, bus.b, bus.c, bus.d}, 64'h28292A2B);

        step("slot0_err", 1, 8'($urandom), 0);
        step("slot0_after", 0, 8'($urandom), 0);

        send_frame("relock", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        step("midframe", 1, 8'($urandom), 1);
        step("midframe", 1, 8'($urandom), 0);
        do_reset("midframe_rst");
        for (int f = 0; f < 3; f++)
            send_frame("post_rst", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        for (int i = 0; i < 400; i++) begin
            bit rv, rfs;
            rv  = ($urandom_range(0, 3) != 0);
            rfs = (!m_locked || m_pos == 0) ^ ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 149) == 0) do_reset("rand_rst");
            else step("rand", rv, 8'($urandom), rfs);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
